ahb_sram_subordinate: RTL

Synthesizable AHB subordinate with single-port SRAM storage. It terminates the bus driven by `ahb_manager`. It accepts SINGLE and INCR/INCRx bursts of any legal size up to the data width, and inserts a parameterised number of wait states per transfer. Illegal transfers get the two-cycle ERROR response. It replaces the behavioural subordinate model in system builds and gives the manager a deterministic, checkable responder.

---
 rtl/ahb_sram_subordinate_if.sv | 44 ++++
 rtl/ahb_sram_subordinate.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_subordinate_if.sv
// ----------------------------------------------------------------------------
// ahb_sram_subordinate_if
// Groups the AHB bus signals that run between ahb_manager and
// ahb_sram_subordinate. The signal names keep the i_/o_ direction prefixes as
// seen from the subordinate, so they match the rest of the codebase.
//
// Parameter: DATA_WDT - data bus width (32, 64 or 128).
// Signals (the manager drives i_*, the subordinate drives o_*):
//   i_hsel    subordinate select
//   i_haddr   byte address
//   i_htrans  IDLE/BUSY/NONSEQ/SEQ
//   i_hwrite  1 = write
//   i_hsize   log2 of transfer bytes
//   i_hburst  burst type
//   i_hwdata  write data (data phase)
//   o_hrdata  read data, full word
//   o_hready  transfer done / address-phase accept
//   o_hresp   OKAY=0, ERROR=1
// Modports: master (bus manager side), slave (subordinate side).
// ----------------------------------------------------------------------------
interface ahb_sram_subordinate_if #(
  parameter int DATA_WDT = 32
) ();
  logic                i_hsel;
  logic [31:0]         i_haddr;
  logic [1:0]          i_htrans;
  logic                i_hwrite;
  logic [2:0]          i_hsize;
  logic [2:0]          i_hburst;
  logic [DATA_WDT-1:0] i_hwdata;
  logic [DATA_WDT-1:0] o_hrdata;
  logic                o_hready;
  logic [1:0]          o_hresp;

  modport master (
    output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata,
    input  o_hrdata, o_hready, o_hresp
  );

  modport slave (
    input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata,
    output o_hrdata, o_hready, o_hresp
  );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// ----------------------------------------------------------------------------
// ahb_sram_subordinate
// AHB subordinate backed by a single-port SRAM array. It accepts SINGLE and
// INCR bursts of any size up to the data width, inserts WAIT_STATES wait
// cycles per legal transfer and answers illegal transfers (out of range,
// misaligned, oversize) with the two-cycle ERROR response without touching
// memory.
//
// Parameters:
//   DATA_WDT    data width (32, 64, 128)
//   MEM_DEPTH   number of DATA_WDT-wide words
//   BASE_ADDR   byte address of word 0 (DATA_WDT/8 aligned)
//   WAIT_STATES wait cycles per OKAY transfer (0..15)
// Ports:
//   i_hclk      clock
//   i_hreset_n  asynchronous active-low reset
//   bus         AHB signals, slave modport of ahb_sram_subordinate_if
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module ahb_sram_subordinate #(
  parameter int          DATA_WDT    = 32,
  parameter int          MEM_DEPTH   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input logic                    i_hclk,
  input logic                    i_hreset_n,
  ahb_sram_subordinate_if.slave  bus
);

  localparam int          BYTES      = DATA_WDT / 8;
  localparam int          LOG2_BYTES = $clog2(BYTES);
  localparam int          IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] MEM_BYTES  = 33'(MEM_DEPTH) * 33'(BYTES);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_OKAY = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       hready_reg, hready_next;
  logic [1:0] hresp_reg, hresp_next;

  // ---------------------------------------------------------------- decode
  // The subtraction wraps for addresses below BASE_ADDR, so a single unsigned
  // compare covers both ends of the window.
  logic [31:0]      offset;
  logic             in_range;
  logic [31:0]      size_mask;
  logic             aligned;
  logic             size_ok;
  logic [IDX_W-1:0] cur_idx;
  logic [8:0]       lane_lo;
  logic [8:0]       lane_end;
  logic [BYTES-1:0] cur_mask;
  logic             sample;
  logic             legal;

  assign offset    = bus.i_haddr - BASE_ADDR;
  assign in_range  = {1'b0, offset} < MEM_BYTES;
  assign size_mask = (32'd1 << bus.i_hsize) - 32'd1;
  assign aligned   = (bus.i_haddr & size_mask) == 32'd0;
  assign size_ok   = bus.i_hsize <= 3'(LOG2_BYTES);
  assign cur_idx   = offset[LOG2_BYTES +: IDX_W];
  assign lane_lo   = 9'(offset[LOG2_BYTES-1:0]);
  assign lane_end  = lane_lo + (9'd1 << bus.i_hsize);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign cur_mask[gi] = (9'(gi) >= lane_lo) && (9'(gi) < lane_end);
    end
  endgenerate

  // An address phase is taken on every edge where hready is high (S_OKAY or
  // S_ERR2); IDLE/BUSY or an unselected bus simply produces no transfer.
  assign sample = hready_reg & bus.i_hsel & bus.i_htrans[1];
  assign legal  = sample & in_range & aligned & size_ok;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_reg  <= S_OKAY;
      cnt_reg    <= 4'd0;
      hready_reg <= 1'b1;
      hresp_reg  <= 2'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hready_reg <= hready_next;
      hresp_reg  <= hresp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_OKAY, S_ERR2: begin
        state_next = S_OKAY;
        if (sample) begin
          if (!legal) begin
            state_next = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next = S_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = S_OKAY;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_ERR1: state_next = S_ERR2;
      default: state_next = S_OKAY;
    endcase
    // Outputs are decoded from the next state and registered, so they never
    // depend combinationally on bus inputs.
    hready_next = (state_next == S_OKAY) || (state_next == S_ERR2);
    hresp_next  = ((state_next == S_ERR1) || (state_next == S_ERR2)) ? 2'd1 : 2'd0;
  end

  // ---------------------------------------------------------------- data phase
  logic             pend_reg;
  logic             wr_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [BYTES-1:0] mask_reg;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      pend_reg <= 1'b0;
      wr_reg   <= 1'b0;
      idx_reg  <= '0;
      mask_reg <= '0;
    end else if (hready_reg) begin
      // Every hready-high edge closes the current data phase and opens the next.
      pend_reg <= legal;
      wr_reg   <= bus.i_hwrite;
      idx_reg  <= cur_idx;
      mask_reg <= cur_mask;
    end
  end

  // A pending legal transfer with hready high is in its final cycle (S_OKAY).
  logic commit;
  assign commit = pend_reg & wr_reg & hready_reg;

  // With no wait states the read word is fetched on the address edge itself;
  // otherwise it is fetched as the wait counter expires.
  logic             rd_load;
  logic [IDX_W-1:0] rd_idx;
  assign rd_load = (WAIT_STATES == 0) ? (legal & ~bus.i_hwrite)
                                      : ((state_reg == S_WAIT) && (cnt_reg == 4'd0) &&
                                         pend_reg && !wr_reg);
  assign rd_idx  = (WAIT_STATES == 0) ? cur_idx : idx_reg;

  // ---------------------------------------------------------------- storage
  logic [DATA_WDT-1:0] mem [MEM_DEPTH];
  logic [DATA_WDT-1:0] mem_word;
  logic [DATA_WDT-1:0] fwd_word;
  logic [DATA_WDT-1:0] hrdata_reg;

  always_ff @(posedge i_hclk) begin
    if (commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mask_reg[b]) begin
          mem[idx_reg][b*8 +: 8] <= bus.i_hwdata[b*8 +: 8];
        end
      end
    end
  end

  assign mem_word = mem[rd_idx];

  // A read fetched on the same edge as a write commit to the same word sees
  // the committing bytes rather than the old array contents.
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_fwd
      assign fwd_word[gi*8 +: 8] = (commit && (rd_idx == idx_reg) && mask_reg[gi])
                                   ? bus.i_hwdata[gi*8 +: 8] : mem_word[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      hrdata_reg <= '0;
    end else if (rd_load) begin
      hrdata_reg <= fwd_word;
    end
  end

  assign bus.o_hrdata = hrdata_reg;
  assign bus.o_hready = hready_reg;
  assign bus.o_hresp  = hresp_reg;

  // Burst type is accepted but not interpreted; BUSY and IDLE differ only in
  // htrans[0], which the subordinate does not need.
  logic unused_ok;
  assign unused_ok = ^{bus.i_hburst, bus.i_htrans[0]};

endmodule
